// File: rtl/dac_update_seq.sv
// dac_update_seq: accumulates signed PID corrections into a saturating
// 16-bit DAC code and sends every new code to a byte-wide SPI master as a
// two-byte frame (high byte first) over a ready/valid handshake.
// Optional feature macro: DAC_SLEW_LIMIT_EN (limits each correction to
// +/-MAX_STEP before accumulation; MAX_STEP only exists when it is defined).

`timescale 1ns/1ps

module dac_update_seq #(
    parameter logic [15:0] INIT_VAL  = 16'h9E23,
    parameter logic [15:0] DAC_MIN   = 16'h0000,
    parameter logic [15:0] DAC_MAX   = 16'hFFFF,
    parameter logic [15:0] FRAME_GAP = 16'd64
`ifdef DAC_SLEW_LIMIT_EN
    ,
    parameter logic [15:0] MAX_STEP  = 16'd256
`endif
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [15:0] pid_out,
    input  logic        pid_valid,
    input  logic        spi_tx_ready,
    output logic [7:0]  spi_tx_byte,
    output logic        spi_tx_dv,
    output logic [15:0] dac_val,
    output logic        busy,
    output logic        sat_hi,
    output logic        sat_lo,
    input  logic        sat_clr,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        WAIT_HI,
        LOAD_LO,
        WAIT_LO
    } state_t;

    localparam logic signed [17:0] MinSum = {2'b00, DAC_MIN};
    localparam logic signed [17:0] MaxSum = {2'b00, DAC_MAX};
`ifdef DAC_SLEW_LIMIT_EN
    localparam logic signed [17:0] MaxStep = {2'b00, MAX_STEP};
`endif

    state_t             state_q, state_d;
    logic               skip_q, skip_d;
    logic [15:0]        txWord_q, txWord_d;
    logic [15:0]        dac_q, dac_d;
    logic               pending_q, pending_d;
    logic [15:0]        gap_q, gap_d;
    logic [15:0]        frameCnt_q, frameCnt_d;
    logic               satHi_q, satHi_d;
    logic               satLo_q, satLo_d;
    logic [7:0]         byte_q, byte_d;
    logic               strobe;
    logic               clampHi, clampLo;
    logic signed [17:0] step;
    logic signed [17:0] sum;

    // Widen the correction to 18 bits (optionally slew-limited) and form the raw sum.
    always_comb begin
        step = {{2{pid_out[15]}}, pid_out};
`ifdef DAC_SLEW_LIMIT_EN
        if (step > MaxStep) begin
            step = MaxStep;
        end else if (step < -MaxStep) begin
            step = -MaxStep;
        end
`endif
        sum = $signed({2'b00, dac_q}) + step;
    end

    // Clamp the sum into [DAC_MIN, DAC_MAX]; a clamp beats sat_clr on the sticky flags.
    always_comb begin
        clampHi = pid_valid && (sum > MaxSum);
        clampLo = pid_valid && (sum < MinSum);
        dac_d   = dac_q;
        if (pid_valid) begin
            if (clampHi) begin
                dac_d = DAC_MAX;
            end else if (clampLo) begin
                dac_d = DAC_MIN;
            end else begin
                dac_d = sum[15:0];
            end
        end
        satHi_d = clampHi | (satHi_q & ~sat_clr);
        satLo_d = clampLo | (satLo_q & ~sat_clr);
    end

    // Frame sequencer: latch a snapshot of the code, then hand out two bytes with gaps.
    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        txWord_d   = txWord_q;
        pending_d  = pending_q | pid_valid;
        gap_d      = gap_q;
        frameCnt_d = frameCnt_q;
        byte_d     = byte_q;
        strobe     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gap_q != 16'd0) begin
                    gap_d = gap_q - 16'd1;
                end else if (pending_q) begin
                    txWord_d  = dac_q;
                    pending_d = pid_valid;
                    state_d   = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (spi_tx_ready) begin
                    strobe  = 1'b1;
                    byte_d  = txWord_q[15:8];
                    skip_d  = 1'b1;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (spi_tx_ready) begin
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                strobe  = 1'b1;
                byte_d  = txWord_q[7:0];
                skip_d  = 1'b1;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (spi_tx_ready) begin
                    frameCnt_d = frameCnt_q + 16'd1;
                    gap_d      = FRAME_GAP;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers; reset restarts with the INIT_VAL frame queued in LOAD_HI.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD_HI;
            skip_q     <= 1'b0;
            txWord_q   <= INIT_VAL;
            dac_q      <= INIT_VAL;
            pending_q  <= 1'b0;
            gap_q      <= 16'd0;
            frameCnt_q <= 16'd0;
            satHi_q    <= 1'b0;
            satLo_q    <= 1'b0;
            byte_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            txWord_q   <= txWord_d;
            dac_q      <= dac_d;
            pending_q  <= pending_d;
            gap_q      <= gap_d;
            frameCnt_q <= frameCnt_d;
            satHi_q    <= satHi_d;
            satLo_q    <= satLo_d;
            byte_q     <= byte_d;
        end
    end

    // The strobe is gated by reset so an abandoned frame never emits a byte.
    assign spi_tx_dv   = strobe & ~reset;
    assign spi_tx_byte = spi_tx_dv ? byte_d : byte_q;
    assign dac_val     = dac_q;
    assign busy        = pending_q | (state_q != IDLE);
    assign sat_hi      = satHi_q;
    assign sat_lo      = satLo_q;
    assign frame_count = frameCnt_q;

endmodule

// File: doc/dac_update_seq.md
Name: dac_update_seq

Overview:
- Downstream stage of the DPLL loop filter; sits between the PID output and the byte-wide DAC SPI master.
- Accumulates each signed PID correction into a 16-bit unsigned DAC code with saturation.
- Serialises every new code to the SPI master as a two-byte frame, high byte first, using a ready/valid handshake.
- Replaces the free-running byte scheduler and guarantees that no update is lost or torn while a frame is in flight.

Parameters:
- INIT_VAL, 16'h9E23, DAC code loaded at reset and sent as the first frame after reset release.
- DAC_MIN, 16'h0000, lower clamp for the DAC code.
- DAC_MAX, 16'hFFFF, upper clamp for the DAC code; requires DAC_MIN <= DAC_MAX.
- FRAME_GAP, 16'd64, minimum idle clk50 cycles between the end of one frame (low byte accepted) and the next high-byte spi_tx_dv.
- MAX_STEP, 16'd256, per-update step limit; used only when DAC_SLEW_LIMIT_EN is defined.

Ports:
- clk50  in  1  system clock (50 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- pid_out  in  16  signed correction, two's complement; sampled only when pid_valid=1.
- pid_valid  in  1  one-cycle strobe, already synchronous to clk50.
- spi_tx_ready  in  1  SPI master ready to accept a byte.
- spi_tx_byte  out  8  byte presented to the SPI master.
- spi_tx_dv  out  1  one-cycle byte-valid strobe.
- dac_val  out  16  current committed DAC code.
- busy  out  1  high while a frame is pending or in flight.
- sat_hi  out  1  sticky flag: the clamp to DAC_MAX has occurred.
- sat_lo  out  1  sticky flag: the clamp to DAC_MIN has occurred.
- sat_clr  in  1  clears sat_hi and sat_lo; a clamp in the same cycle wins.
- frame_count  out  16  frames completed; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset values:
  - dac_val=INIT_VAL, spi_tx_byte=0, spi_tx_dv=0.
  - sat_hi=0, sat_lo=0, frame_count=0, pending=0, gap counter=0.
  - State = LOAD_HI with the send flag set, so INIT_VAL is sent after reset.
- Accumulation, every cycle pid_valid=1:
  - sum = {1'b0,dac_val} + sign-extended pid_out, computed at 18 bits signed.
  - If sum > DAC_MAX, the result is DAC_MAX and sat_hi is set. If sum < DAC_MIN, the result is DAC_MIN and sat_lo is set.
  - dac_val takes the result the next cycle (1-cycle latency).
  - pending is set the same cycle.
- Updates during a frame:
  - dac_val keeps accumulating while a frame is in flight.
  - The in-flight frame uses the latched copy tx_word, so it is never torn.
  - pending remains a single flag; multiple updates coalesce into one frame carrying the latest dac_val.
- FSM:
  - IDLE: if pending and the gap counter = 0 -> LOAD_HI. In the same cycle, tx_word <= dac_val and pending <= 0. If pid_valid=1 in that same cycle, pending is set again.
  - LOAD_HI: wait for spi_tx_ready=1. Then spi_tx_byte=tx_word[15:8], spi_tx_dv=1 for one cycle -> WAIT_HI.
  - WAIT_HI: ignore spi_tx_ready for 1 cycle, then wait for spi_tx_ready=1 -> LOAD_LO.
  - LOAD_LO: spi_tx_byte=tx_word[7:0], spi_tx_dv=1 for one cycle -> WAIT_LO.
  - WAIT_LO: ignore 1 cycle, then wait for spi_tx_ready=1. frame_count++ and the gap counter loads FRAME_GAP -> IDLE.
- Gap counter decrements in IDLE down to 0.
- Latency: pid_valid in IDLE with gap=0 and spi_tx_ready=1 -> dac_val updates at +1 and the high-byte spi_tx_dv fires at +2.
- spi_tx_dv is never high on two consecutive cycles.
- spi_tx_byte holds its value between strobes.
- busy = pending OR (state != IDLE).
- Reset mid-frame: everything returns to reset values immediately. The partial frame is abandoned; the SPI master's own reset handles its CS.

Optional Feature:
- Macro: DAC_SLEW_LIMIT_EN.
- Defined: pid_out is clamped to [-MAX_STEP, +MAX_STEP] before accumulation. Step clamping does not set sat_hi or sat_lo; the DAC_MIN/DAC_MAX clamps still apply afterwards.
- Undefined: pid_out is used unmodified, MAX_STEP is ignored, and no slew logic is synthesised.

Test Plan:
- Reset release, spi_tx_ready=1 -> frame bytes 8'h9E then 8'h23, frame_count=1, dac_val=16'h9E23.
- Idle, pid_out=+16'd5 pulse -> dac_val=16'h9E28 next cycle, frame 9E/28, spi_tx_dv at +2.
- dac_val=16'hFFF0, pid_out=+16'd100 -> dac_val=16'hFFFF, sat_hi=1. Then sat_clr=1 -> sat_hi=0.
- Three pid_valid pulses (+1, +2, +3) during an in-flight frame of 16'h1000 -> current frame stays 10/00, then exactly one further frame 10/06 after FRAME_GAP cycles.
- Reset asserted between the high and low byte -> no further spi_tx_dv, outputs at reset values, INIT_VAL frame resent after release.
- DAC_SLEW_LIMIT_EN defined, MAX_STEP=256, pid_out=-16'd1000 from 16'h9E23 -> dac_val=16'h9D23, sat_lo=0.
